// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus between NUM_REQ masters; grant held for a whole burst.
// Optional watchdog enabled by defining CBUS_ARB_TIMEOUT_EN. Packing: req={valid,write,len[7:0],addr[31:0],wdata[31:0]}, resp={ready,last,rdata[31:0]}.
module cbus_rr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int REQ_W         = 74,
  localparam int RESP_W        = 34,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ*REQ_W-1:0]  ireqs,
  output logic [NUM_REQ*RESP_W-1:0] iresps,
  output logic [REQ_W-1:0]          oreq,
  input  logic [RESP_W-1:0]         oresp,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [REQ_W-1:0] owner_req;
  logic             owner_valid;
  logic             resp_ready;
  logic             resp_last;

  assign resp_ready  = oresp[RESP_W-1];
  assign resp_last   = oresp[RESP_W-2];
  assign owner_req   = ireqs[int'(owner_q)*REQ_W +: REQ_W];
  assign owner_valid = owner_req[REQ_W-1];

  // Search starts just after the previous owner so the released master is last in line.
  always_comb begin
    int idx;
    idx    = 0;
    winner = owner_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_ptr_q) + i) % NUM_REQ;
      if (!found && ireqs[idx*REQ_W + REQ_W-1]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = winner;
        end
      end
      BUSY: begin
        if (!owner_valid || (resp_ready && resp_last)) begin
          state_d    = IDLE;
          last_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_ptr_q <= IDX_W'(NUM_REQ-1);
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them asynchronously.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == BUSY) begin
      oreq                                     = owner_req;
      iresps[int'(owner_q)*RESP_W +: RESP_W]   = oresp;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = owner_q;

`ifdef CBUS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q != BUSY || resp_ready) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (state_q == BUSY && cnt_q == 16'(TIMEOUT_CYCLES-1)) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

`ifndef SYNTHESIS
  // Owner dropping valid mid-burst is a protocol violation even though the FSM recovers.
  owner_hold_a: assert property (@(posedge clk) disable iff (!resetn)
                                 (state_q == BUSY) |-> owner_valid);
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter with two masters and an 8-cycle watchdog limit.
module tb_cbus_rr_arbiter;

  localparam int REQ_W  = 74;
  localparam int RESP_W = 34;
`ifdef CBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk;
  logic                  resetn;
  logic [2*REQ_W-1:0]    ireqs;
  logic [2*RESP_W-1:0]   iresps;
  logic [REQ_W-1:0]      oreq;
  logic [RESP_W-1:0]     oresp;
  logic                  busy;
  logic                  grant_idx;
  logic                  timeout_err;

  int checks = 0;
  int fails  = 0;

  logic [REQ_W-1:0]  r0, r1;
  logic [RESP_W-1:0] rs;

  cbus_rr_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx),
    .timeout_err(timeout_err)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(bit v, bit w, logic [7:0] len,
                                              logic [31:0] a, logic [31:0] d);
    return {v, w, len, a, d};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(bit rdy, bit last, logic [31:0] d);
    return {rdy, last, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    #3;
    checks++; if (oreq !== '0) begin fails++; $display("[TB] FAIL rst_oreq: got %h want 0", oreq); end
    checks++; if (iresps !== '0) begin fails++; $display("[TB] FAIL rst_iresps: got %h want 0", iresps); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_idx !== 1'b0) begin fails++; $display("[TB] FAIL rst_grant: got %b want 0", grant_idx); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_timeout: got %b want 0", timeout_err); end
    @(negedge clk) resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single_master();
    r0 = mk_req(1, 0, 8'd3, 32'h1000, 32'h0);
    ireqs = {REQ_W'(0), r0};
    mid();
    checks++; if (oreq[REQ_W-1] !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t1_arb_cycle: got valid=%b busy=%b want 0 0", oreq[REQ_W-1], busy); end
    cyc();
    for (int b = 0; b < 4; b++) begin
      rs = mk_resp(1, b == 3, 32'hA000 + b);
      oresp = rs;
      mid();
      checks++; if (oreq !== r0) begin fails++; $display("[TB] FAIL t1_oreq beat%0d: got %h want %h", b, oreq, r0); end
      checks++; if (iresps[RESP_W-1:0] !== rs) begin fails++; $display("[TB] FAIL t1_iresp0 beat%0d: got %h want %h", b, iresps[RESP_W-1:0], rs); end
      checks++; if (iresps[2*RESP_W-1:RESP_W] !== '0) begin fails++; $display("[TB] FAIL t1_iresp1 beat%0d: got %h want 0", b, iresps[2*RESP_W-1:RESP_W]); end
      cyc();
    end
    ireqs = '0;
    oresp = '0;
    mid();
    checks++; if (busy !== 1'b0 || oreq !== '0) begin fails++; $display("[TB] FAIL t1_release: got busy=%b oreq=%h want 0 0", busy, oreq); end
    checks++; if (grant_idx !== 1'b0) begin fails++; $display("[TB] FAIL t1_grant_hold: got %b want 0", grant_idx); end
    cyc();
  endtask

  task automatic test_both_valid();
    resetn = 1'b0;
    #1;
    r0 = mk_req(1, 1, 8'd0, 32'h2000, 32'h0000_00D0);
    r1 = mk_req(1, 0, 8'd0, 32'h3000, 32'h0);
    ireqs = {r1, r0};
    oresp = mk_resp(1, 1, 32'hB0);
    @(negedge clk) resetn = 1'b1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL t2_idle: got busy=%b want 0", busy); end
    cyc(); mid();
    checks++; if (grant_idx !== 1'b0 || oreq !== r0) begin fails++; $display("[TB] FAIL t2_first: got grant=%b oreq=%h want 0 %h", grant_idx, oreq, r0); end
    checks++; if (iresps[2*RESP_W-1:RESP_W] !== '0) begin fails++; $display("[TB] FAIL t2_loser_resp: got %h want 0", iresps[2*RESP_W-1:RESP_W]); end
    cyc(); mid();
    checks++; if (busy !== 1'b0 || oreq !== '0) begin fails++; $display("[TB] FAIL t2_bubble: got busy=%b oreq=%h want 0 0", busy, oreq); end
    cyc(); mid();
    checks++; if (grant_idx !== 1'b1 || oreq !== r1) begin fails++; $display("[TB] FAIL t2_second: got grant=%b oreq=%h want 1 %h", grant_idx, oreq, r1); end
    checks++; if (iresps[2*RESP_W-1:RESP_W] !== oresp || iresps[RESP_W-1:0] !== '0) begin fails++; $display("[TB] FAIL t2_resp_route: got %h want %h", iresps, {oresp, RESP_W'(0)}); end
    cyc(); mid();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL t2_bubble2: got busy=%b want 0", busy); end
    cyc(); mid();
    checks++; if (grant_idx !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL t2_third: got grant=%b busy=%b want 0 1", grant_idx, busy); end
    cyc();
    ireqs = '0;
    oresp = '0;
    mid();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL t2_end: got busy=%b want 0", busy); end
    cyc();
  endtask

  task automatic test_mid_burst_request();
    r0 = mk_req(1, 0, 8'd2, 32'h4000, 32'h0);
    r1 = mk_req(1, 1, 8'd0, 32'h5000, 32'h55);
    ireqs = {REQ_W'(0), r0};
    cyc();
    for (int b = 0; b < 3; b++) begin
      rs = mk_resp(1, b == 2, 32'hC0 + b);
      oresp = rs;
      if (b == 1) ireqs = {r1, r0};
      mid();
      checks++; if (oreq !== r0) begin fails++; $display("[TB] FAIL t3_oreq beat%0d: got %h want %h", b, oreq, r0); end
      checks++; if (iresps[2*RESP_W-1:RESP_W] !== '0 || iresps[RESP_W-1:0] !== rs) begin fails++; $display("[TB] FAIL t3_resp beat%0d: got %h want %h", b, iresps, {RESP_W'(0), rs}); end
      cyc();
    end
    ireqs = {r1, REQ_W'(0)};
    oresp = '0;
    mid();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL t3_bubble: got busy=%b want 0", busy); end
    cyc();
    oresp = mk_resp(1, 1, 32'h77);
    mid();
    checks++; if (grant_idx !== 1'b1 || oreq !== r1) begin fails++; $display("[TB] FAIL t3_waiter: got grant=%b oreq=%h want 1 %h", grant_idx, oreq, r1); end
    cyc();
    ireqs = '0;
    oresp = '0;
    cyc();
  endtask

  task automatic test_single_beat();
    r0 = mk_req(1, 1, 8'd0, 32'h6000, 32'h66);
    r1 = mk_req(1, 0, 8'd0, 32'h7000, 32'h0);
    ireqs = {REQ_W'(0), r0};
    cyc();
    oresp = mk_resp(1, 1, 32'h88);
    mid();
    checks++; if (grant_idx !== 1'b0 || iresps[RESP_W-1:0] !== oresp) begin fails++; $display("[TB] FAIL t4_beat: got grant=%b iresp0=%h want 0 %h", grant_idx, iresps[RESP_W-1:0], oresp); end
    cyc();
    ireqs = {r1, r0};
    oresp = '0;
    mid();
    checks++; if (busy !== 1'b0 || grant_idx !== 1'b0) begin fails++; $display("[TB] FAIL t4_idle: got busy=%b grant=%b want 0 0", busy, grant_idx); end
    cyc(); mid();
    checks++; if (grant_idx !== 1'b1 || oreq !== r1) begin fails++; $display("[TB] FAIL t4_rr: got grant=%b oreq=%h want 1 %h", grant_idx, oreq, r1); end
    oresp = mk_resp(1, 1, 32'h99);
    cyc();
    ireqs = '0;
    oresp = '0;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    ireqs = {REQ_W'(0), mk_req(1, 0, 8'd0, 32'h7100, 32'h0)};
    cyc();
    oresp = mk_resp(1, 1, 32'h0);
    cyc();
    ireqs = '0;
    oresp = '0;
    r1 = mk_req(1, 0, 8'd3, 32'h8000, 32'h0);
    ireqs = {r1, REQ_W'(0)};
    cyc();
    for (int b = 0; b < 2; b++) begin
      oresp = mk_resp(1, 0, 32'hE0 + b);
      cyc();
    end
    oresp = mk_resp(1, 0, 32'hE2);
    mid();
    checks++; if (oreq !== r1) begin fails++; $display("[TB] FAIL t5_pre: got %h want %h", oreq, r1); end
    resetn = 1'b0;
    #1;
    checks++; if (oreq !== '0 || iresps !== '0) begin fails++; $display("[TB] FAIL t5_async_clear: got oreq=%h iresps=%h want 0 0", oreq, iresps); end
    checks++; if (busy !== 1'b0 || grant_idx !== 1'b0) begin fails++; $display("[TB] FAIL t5_async_state: got busy=%b grant=%b want 0 0", busy, grant_idx); end
    r0 = mk_req(1, 0, 8'd0, 32'h9000, 32'h0);
    r1 = mk_req(1, 0, 8'd0, 32'h9100, 32'h0);
    ireqs = {r1, r0};
    oresp = '0;
    @(negedge clk) resetn = 1'b1;
    cyc(); mid();
    checks++; if (grant_idx !== 1'b0 || oreq !== r0) begin fails++; $display("[TB] FAIL t5_regrant: got grant=%b oreq=%h want 0 %h", grant_idx, oreq, r0); end
    oresp = mk_resp(1, 1, 32'h0);
    cyc();
    ireqs = '0;
    oresp = '0;
    cyc();
  endtask

  task automatic test_timeout();
    logic exp_err;
    r0 = mk_req(1, 0, 8'd0, 32'hA000, 32'h0);
    ireqs = {REQ_W'(0), r0};
    oresp = '0;
    cyc();
    for (int k = 1; k <= 12; k++) begin
      mid();
      exp_err = TO_EN && (k >= 9);
      checks++; if (timeout_err !== exp_err) begin fails++; $display("[TB] FAIL t6_err cycle%0d: got %b want %b", k, timeout_err, exp_err); end
      checks++; if (busy !== 1'b1 || grant_idx !== 1'b0) begin fails++; $display("[TB] FAIL t6_hold cycle%0d: got busy=%b grant=%b want 1 0", k, busy, grant_idx); end
      cyc();
    end
    oresp = mk_resp(1, 1, 32'h5A);
    mid();
    checks++; if (iresps[RESP_W-1:0] !== oresp) begin fails++; $display("[TB] FAIL t6_complete: got %h want %h", iresps[RESP_W-1:0], oresp); end
    cyc();
    ireqs = '0;
    oresp = '0;
    mid();
    checks++; if (busy !== 1'b0 || timeout_err !== TO_EN) begin fails++; $display("[TB] FAIL t6_sticky: got busy=%b err=%b want 0 %b", busy, timeout_err, TO_EN); end
    cyc();
  endtask

  // Scenarios run in order; each one leaves the arbiter idle with no requests pending
  initial begin
    test_reset();
    test_single_master();
    test_both_valid();
    test_mid_burst_request();
    test_single_beat();
    test_reset_mid_burst();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
